// File: rtl/seed_link.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seed_link
//   Exchanges point seeds between two boards over a byte-level UART.
//   TX side: a seed_rdy strobe latches seed_x/seed_y and sends the 4-byte frame
//   A5, {3'b0,x}, {3'b0,y}, CHK where CHK = A5 ^ byte1 ^ byte2.
//   RX side: parses the peer frame. A good frame updates seed_x_rx/seed_y_rx
//   and pulses remote_start. Bad format, bad checksum or an inter-byte timeout
//   pulses link_err.
//
// Optional feature (macro SEED_LINK_ACK_EN):
//   Each good RX frame is answered with a single 0x5A byte. After sending a
//   frame, TX waits in T_ACKW for a 0x5A from the peer. If none arrives, the
//   frame is resent up to MAX_RETRY times, then link_err pulses.
//   Without the macro there is no ACK byte and no wait state, and a 0x5A seen
//   while hunting for a header is dropped as junk.
//
// Ports
//   clk_75        in   system clock
//   rst           in   synchronous active-high reset
//   seed_rdy      in   strobe: latch seed_x/seed_y and send a frame
//   seed_x/seed_y in   5-bit local seed
//   tx_data       out  byte to UART TX, stable while stalled
//   tx_valid      out  tx_data valid, held until tx_ready
//   tx_ready      in   UART TX accepts on tx_valid && tx_ready
//   rx_data       in   byte from UART RX
//   rx_valid      in   strobe qualifying rx_data
//   seed_x_rx/_y  out  last good received seed
//   remote_start  out  1-cycle pulse per good received frame
//   tx_busy       out  TX FSM not idle
//   link_err      out  1-cycle error pulse
// -----------------------------------------------------------------------------
module seed_link #(
  parameter int unsigned TIMEOUT_CYCLES  = 750000
`ifdef SEED_LINK_ACK_EN
  ,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned ACK_WAIT_CYCLES = 1500000
`endif
) (
  input  logic       clk_75,
  input  logic       rst,
  input  logic       seed_rdy,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x_rx,
  output logic [4:0] seed_y_rx,
  output logic       remote_start,
  output logic       tx_busy,
  output logic       link_err
);

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h5A;

  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef SEED_LINK_ACK_EN
  localparam int unsigned    RT_W      = $clog2(MAX_RETRY + 2);
  localparam logic [RT_W-1:0] RT_MAX    = RT_W'(MAX_RETRY);
  localparam int unsigned    AW_W      = $clog2(ACK_WAIT_CYCLES + 1);
  localparam logic [AW_W-1:0] WAIT_LAST = AW_W'(ACK_WAIT_CYCLES - 1);
`endif

  // Frame checksum over the header and the two zero-padded seed bytes.
  function automatic logic [7:0] frame_chk(input logic [4:0] x, input logic [4:0] y);
    frame_chk = HDR_BYTE ^ {3'b000, x} ^ {3'b000, y};
  endfunction

  typedef enum logic [2:0] {
    T_IDLE,
    T_HDR,
    T_SX,
    T_SY,
    T_CHK
`ifdef SEED_LINK_ACK_EN
    ,
    T_ACK,
    T_ACKW
`endif
  } tx_state_e;

  typedef enum logic [1:0] {
    R_HDR,
    R_SX,
    R_SY,
    R_CHK
  } rx_state_e;

  // ---------------- state ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [4:0]      tx_x_q, tx_x_d, tx_y_q, tx_y_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_busy_q, tx_busy_d;
  logic            tx_fire_s;
  logic            tx_giveup_s;

  rx_state_e       rx_state_q, rx_state_d;
  logic [4:0]      rx_sx_q, rx_sx_d, rx_sy_q, rx_sy_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [4:0]      seed_x_rx_q, seed_x_rx_d, seed_y_rx_q, seed_y_rx_d;
  logic            remote_start_q, remote_start_d;
  logic            link_err_q, link_err_d;
  logic            rx_err_s;
  logic            frame_ok_s;

`ifdef SEED_LINK_ACK_EN
  logic            ack_pend_q, ack_pend_d;   // ACK owed to the peer
  logic            ret_ackw_q, ret_ackw_d;   // ACK byte inserted while waiting: resume T_ACKW
  logic [RT_W-1:0] retry_q, retry_d;
  logic [AW_W-1:0] wait_q, wait_d;
  logic            ack_seen_s;

  assign ack_seen_s = (rx_state_q == R_HDR) && rx_valid && (rx_data == ACK_BYTE);
`endif

  assign tx_fire_s = tx_valid_q && tx_ready;

  // TX next-state: frame sequencing, plus ACK insertion and retry when enabled.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_x_d      = tx_x_q;
    tx_y_d      = tx_y_q;
    tx_giveup_s = 1'b0;
`ifdef SEED_LINK_ACK_EN
    ack_pend_d  = ack_pend_q | frame_ok_s;
    ret_ackw_d  = ret_ackw_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
`endif
    case (tx_state_q)
      T_IDLE: begin
`ifdef SEED_LINK_ACK_EN
        if (ack_pend_q) begin
          tx_state_d = T_ACK;
          ret_ackw_d = 1'b0;
        end else
`endif
        if (seed_rdy) begin
          tx_x_d     = seed_x;
          tx_y_d     = seed_y;
          tx_state_d = T_HDR;
`ifdef SEED_LINK_ACK_EN
          retry_d    = '0;
`endif
        end else begin
          tx_state_d = T_IDLE;
        end
      end
      T_HDR: begin
        if (tx_fire_s) tx_state_d = T_SX;
        else           tx_state_d = T_HDR;
      end
      T_SX: begin
        if (tx_fire_s) tx_state_d = T_SY;
        else           tx_state_d = T_SX;
      end
      T_SY: begin
        if (tx_fire_s) tx_state_d = T_CHK;
        else           tx_state_d = T_SY;
      end
      T_CHK: begin
        if (tx_fire_s) begin
`ifdef SEED_LINK_ACK_EN
          wait_d = '0;
          if (ack_pend_q) begin
            tx_state_d = T_ACK;
            ret_ackw_d = 1'b1;
          end else begin
            tx_state_d = T_ACKW;
          end
`else
          tx_state_d = T_IDLE;
`endif
        end else begin
          tx_state_d = T_CHK;
        end
      end
`ifdef SEED_LINK_ACK_EN
      T_ACK: begin
        if (tx_fire_s) begin
          ack_pend_d = frame_ok_s;
          if (ret_ackw_q && !ack_seen_s) tx_state_d = T_ACKW;
          else                           tx_state_d = T_IDLE;
        end else if (ack_seen_s) begin
          // Peer acknowledged while our ACK byte was stalled: no need to wait.
          ret_ackw_d = 1'b0;
        end else begin
          tx_state_d = T_ACK;
        end
      end
      T_ACKW: begin
        if (ack_seen_s) begin
          tx_state_d = T_IDLE;
        end else if (ack_pend_q) begin
          // Answer the peer now so two waiting boards cannot starve each other.
          tx_state_d = T_ACK;
          ret_ackw_d = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          wait_d = '0;
          if (retry_q == RT_MAX) begin
            tx_giveup_s = 1'b1;
            tx_state_d  = T_IDLE;
          end else begin
            retry_d    = retry_q + RT_W'(1);
            tx_state_d = T_HDR;
          end
        end else begin
          wait_d = wait_q + AW_W'(1);
        end
      end
`endif
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX output decode from the next state so tx_data/tx_valid come straight from flops.
  always_comb begin
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    case (tx_state_d)
      T_HDR: begin tx_data_d = HDR_BYTE;                 tx_valid_d = 1'b1; end
      T_SX:  begin tx_data_d = {3'b000, tx_x_d};         tx_valid_d = 1'b1; end
      T_SY:  begin tx_data_d = {3'b000, tx_y_d};         tx_valid_d = 1'b1; end
      T_CHK: begin tx_data_d = frame_chk(tx_x_d, tx_y_d); tx_valid_d = 1'b1; end
`ifdef SEED_LINK_ACK_EN
      T_ACK: begin tx_data_d = ACK_BYTE;                 tx_valid_d = 1'b1; end
`endif
      default: begin tx_data_d = 8'h00; tx_valid_d = 1'b0; end
    endcase
    tx_busy_d = (tx_state_d != T_IDLE);
  end

  // RX parser with inter-byte timeout; the timeout only runs mid-frame.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_sx_d        = rx_sx_q;
    rx_sy_d        = rx_sy_q;
    to_d           = to_q;
    seed_x_rx_d    = seed_x_rx_q;
    seed_y_rx_d    = seed_y_rx_q;
    remote_start_d = 1'b0;
    rx_err_s       = 1'b0;
    frame_ok_s     = 1'b0;
    if (rx_valid) begin
      // An arriving byte always wins over an expiring timeout.
      to_d = '0;
      case (rx_state_q)
        R_HDR: begin
          if (rx_data == HDR_BYTE) rx_state_d = R_SX;
          else                     rx_state_d = R_HDR;
        end
        R_SX: begin
          if (rx_data[7:5] != 3'b000) begin
            rx_err_s   = 1'b1;
            rx_state_d = R_HDR;
          end else begin
            rx_sx_d    = rx_data[4:0];
            rx_state_d = R_SY;
          end
        end
        R_SY: begin
          if (rx_data[7:5] != 3'b000) begin
            rx_err_s   = 1'b1;
            rx_state_d = R_HDR;
          end else begin
            rx_sy_d    = rx_data[4:0];
            rx_state_d = R_CHK;
          end
        end
        R_CHK: begin
          if (rx_data == frame_chk(rx_sx_q, rx_sy_q)) begin
            frame_ok_s     = 1'b1;
            seed_x_rx_d    = rx_sx_q;
            seed_y_rx_d    = rx_sy_q;
            remote_start_d = 1'b1;
          end else begin
            rx_err_s = 1'b1;
          end
          rx_state_d = R_HDR;
        end
        default: rx_state_d = R_HDR;
      endcase
    end else if (rx_state_q != R_HDR) begin
      if (to_q == TO_LAST) begin
        rx_err_s   = 1'b1;
        rx_state_d = R_HDR;
        to_d       = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
    link_err_d = rx_err_s | tx_giveup_s;
  end

  // State and output registers.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      tx_state_q     <= T_IDLE;
      tx_x_q         <= 5'd0;
      tx_y_q         <= 5'd0;
      tx_data_q      <= 8'h00;
      tx_valid_q     <= 1'b0;
      tx_busy_q      <= 1'b0;
      rx_state_q     <= R_HDR;
      rx_sx_q        <= 5'd0;
      rx_sy_q        <= 5'd0;
      to_q           <= '0;
      seed_x_rx_q    <= 5'd0;
      seed_y_rx_q    <= 5'd0;
      remote_start_q <= 1'b0;
      link_err_q     <= 1'b0;
`ifdef SEED_LINK_ACK_EN
      ack_pend_q     <= 1'b0;
      ret_ackw_q     <= 1'b0;
      retry_q        <= '0;
      wait_q         <= '0;
`endif
    end else begin
      tx_state_q     <= tx_state_d;
      tx_x_q         <= tx_x_d;
      tx_y_q         <= tx_y_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_busy_q      <= tx_busy_d;
      rx_state_q     <= rx_state_d;
      rx_sx_q        <= rx_sx_d;
      rx_sy_q        <= rx_sy_d;
      to_q           <= to_d;
      seed_x_rx_q    <= seed_x_rx_d;
      seed_y_rx_q    <= seed_y_rx_d;
      remote_start_q <= remote_start_d;
      link_err_q     <= link_err_d;
`ifdef SEED_LINK_ACK_EN
      ack_pend_q     <= ack_pend_d;
      ret_ackw_q     <= ret_ackw_d;
      retry_q        <= retry_d;
      wait_q         <= wait_d;
`endif
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_busy      = tx_busy_q;
  assign seed_x_rx    = seed_x_rx_q;
  assign seed_y_rx    = seed_y_rx_q;
  assign remote_start = remote_start_q;
  assign link_err     = link_err_q;

endmodule
